// File: rtl/pong_ball_engine.sv
// Pong ball-motion engine: steps the ball once per motion tick, bounces off walls and paddles, reports the scorer.
// Build macro BALL_SPEEDUP_EN: each accepted paddle hit raises the step size, saturating at MAX_SPEED.
module pong_ball_engine #(
    parameter int COORD_W   = 10,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BALL_SIZE = 16,
    parameter int TICK_DIV  = 500000,
    parameter int MAX_SPEED = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         state,
    input  logic               serve_dir,
    input  logic               hit_left,
    input  logic               hit_right,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [1:0]         ball_status,
    output logic               tick,
    output logic [2:0]         speed
);
    typedef enum logic [1:0] {
        GS_START = 2'b00,
        GS_SERVE = 2'b01,
        GS_PLAY  = 2'b10,
        GS_DONE  = 2'b11
    } gameState_t;

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [COORD_W-1:0] ORIGIN_X = COORD_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] ORIGIN_Y = COORD_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [COORD_W:0]   MAX_X    = (COORD_W+1)'(SCREEN_W - BALL_SIZE);
    localparam logic [COORD_W:0]   MAX_Y    = (COORD_W+1)'(SCREEN_H - BALL_SIZE);
    localparam logic [1:0] STAT_PLAYING = 2'b00;
    localparam logic [1:0] STAT_P1_WIN  = 2'b01;
    localparam logic [1:0] STAT_P2_WIN  = 2'b10;

    if (TICK_DIV < 2 || MAX_SPEED < 1 || MAX_SPEED > 7 || COORD_W < 3) begin : g_badConfig
        $error("pong_ball_engine: unsupported parameter combination");
    end

`ifdef BALL_SPEEDUP_EN
    localparam logic [2:0] SPEED_MAX = 3'(MAX_SPEED);
`endif

    gameState_t gameState;
    assign gameState = gameState_t'(state);

    logic [COORD_W-1:0] ballXReg, ballXNext;
    logic [COORD_W-1:0] ballYReg, ballYNext;
    logic               dirXReg, dirXNext;
    logic               dirYReg, dirYNext;
    logic [2:0]         speedReg, speedNext;
    logic [1:0]         statusReg, statusNext;
    logic [CNT_W-1:0]   cntReg, cntNext;
    logic               tickReg, tickNext;
    logic               latLeftReg, latLeftNext;
    logic               latRightReg, latRightNext;

    logic               dirXHit;
    logic [2:0]         speedHit;
    logic [COORD_W:0]   stepW, sumX, sumY;

    always_ff @(posedge clk) begin
        if (rst) begin
            ballXReg    <= ORIGIN_X;
            ballYReg    <= ORIGIN_Y;
            dirXReg     <= 1'b0;
            dirYReg     <= 1'b0;
            speedReg    <= 3'd1;
            statusReg   <= STAT_PLAYING;
            cntReg      <= '0;
            tickReg     <= 1'b0;
            latLeftReg  <= 1'b0;
            latRightReg <= 1'b0;
        end else begin
            ballXReg    <= ballXNext;
            ballYReg    <= ballYNext;
            dirXReg     <= dirXNext;
            dirYReg     <= dirYNext;
            speedReg    <= speedNext;
            statusReg   <= statusNext;
            cntReg      <= cntNext;
            tickReg     <= tickNext;
            latLeftReg  <= latLeftNext;
            latRightReg <= latRightNext;
        end
    end

    always_comb begin
        ballXNext    = ballXReg;
        ballYNext    = ballYReg;
        dirXNext     = dirXReg;
        dirYNext     = dirYReg;
        speedNext    = speedReg;
        statusNext   = statusReg;
        cntNext      = cntReg;
        tickNext     = 1'b0;
        latLeftNext  = latLeftReg;
        latRightNext = latRightReg;
        dirXHit      = dirXReg;
        speedHit     = speedReg;
        stepW        = '0;
        sumX         = '0;
        sumY         = '0;

        if (gameState != GS_PLAY) begin
            ballXNext    = ORIGIN_X;
            ballYNext    = ORIGIN_Y;
            dirXNext     = 1'b0;
            dirYNext     = 1'b0;
            speedNext    = 3'd1;
            statusNext   = STAT_PLAYING;
            cntNext      = '0;
            latLeftNext  = 1'b0;
            latRightNext = 1'b0;
            // Toggling dir_y while serving gives the serve angle some entropy.
            if (gameState == GS_SERVE) begin
                dirXNext = serve_dir;
                dirYNext = ~dirYReg;
            end
        end else if (cntReg != CNT_LAST) begin
            cntNext      = cntReg + CNT_W'(1);
            latLeftNext  = latLeftReg | hit_left;
            latRightNext = latRightReg | hit_right;
        end else begin
            cntNext      = '0;
            tickNext     = 1'b1;
            latLeftNext  = 1'b0;
            latRightNext = 1'b0;
            if (statusReg == STAT_PLAYING) begin
                // Only the paddle the ball is heading toward can reverse it.
                if ((latRightReg | hit_right) && !dirXReg) begin
                    dirXHit = 1'b1;
`ifdef BALL_SPEEDUP_EN
                    speedHit = (speedReg < SPEED_MAX) ? speedReg + 3'd1 : speedReg;
`endif
                end else if ((latLeftReg | hit_left) && dirXReg) begin
                    dirXHit = 1'b0;
`ifdef BALL_SPEEDUP_EN
                    speedHit = (speedReg < SPEED_MAX) ? speedReg + 3'd1 : speedReg;
`endif
                end
                dirXNext  = dirXHit;
                speedNext = speedHit;

                // One extra bit keeps the edge tests free of wrap-around.
                stepW = {{(COORD_W-2){1'b0}}, speedHit};
                sumX  = {1'b0, ballXReg} + stepW;
                sumY  = {1'b0, ballYReg} + stepW;

                if (!dirYReg) begin
                    if (sumY >= MAX_Y) begin
                        ballYNext = MAX_Y[COORD_W-1:0];
                        dirYNext  = 1'b1;
                    end else begin
                        ballYNext = sumY[COORD_W-1:0];
                    end
                end else if ({1'b0, ballYReg} <= stepW) begin
                    ballYNext = '0;
                    dirYNext  = 1'b0;
                end else begin
                    ballYNext = ballYReg - stepW[COORD_W-1:0];
                end

                if (!dirXHit) begin
                    if (sumX >= MAX_X) begin
                        ballXNext  = MAX_X[COORD_W-1:0];
                        statusNext = STAT_P1_WIN;
                    end else begin
                        ballXNext = sumX[COORD_W-1:0];
                    end
                end else if ({1'b0, ballXReg} <= stepW) begin
                    ballXNext  = '0;
                    statusNext = STAT_P2_WIN;
                end else begin
                    ballXNext = ballXReg - stepW[COORD_W-1:0];
                end
            end
        end
    end

    assign ball_x      = ballXReg;
    assign ball_y      = ballYReg;
    assign ball_status = statusReg;
    assign tick        = tickReg;
    assign speed       = speedReg;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine on a 64x48 field (ball 4, tick every 4 cycles, max speed 3).
// Reference model works on plain integers from the motion rules; honours BALL_SPEEDUP_EN like the DUT.
module tb_pong_ball_engine;
    localparam int OX = 30, OY = 22, MX = 60, MY = 44, MAXSPD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state = 2'b00;
    logic       serve_dir = 1'b0;
    logic       hit_left = 1'b0;
    logic       hit_right = 1'b0;
    logic [9:0] ball_x, ball_y;
    logic [1:0] ball_status;
    logic       tick;
    logic [2:0] speed;

    int tests = 0;
    int fails = 0;

    // Model state: position, direction (0=+,1=-), step size, score status.
    int mx, my, mdx, mdy, msp, mst;

    pong_ball_engine #(
        .COORD_W(10), .SCREEN_W(64), .SCREEN_H(48), .BALL_SIZE(4),
        .TICK_DIV(4), .MAX_SPEED(MAXSPD)
    ) dut (
        .clk(clk), .rst(rst), .state(state), .serve_dir(serve_dir),
        .hit_left(hit_left), .hit_right(hit_right),
        .ball_x(ball_x), .ball_y(ball_y), .ball_status(ball_status),
        .tick(tick), .speed(speed)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_update(input bit lr, input bit ll);
        if (mst != 0) return;
        if (lr && mdx == 0) begin
            mdx = 1;
`ifdef BALL_SPEEDUP_EN
            if (msp < MAXSPD) msp = msp + 1;
`endif
        end else if (ll && mdx == 1) begin
            mdx = 0;
`ifdef BALL_SPEEDUP_EN
            if (msp < MAXSPD) msp = msp + 1;
`endif
        end
        if (mdy == 0) begin
            if (my + msp >= MY) begin my = MY; mdy = 1; end
            else my = my + msp;
        end else begin
            if (my <= msp) begin my = 0; mdy = 0; end
            else my = my - msp;
        end
        if (mdx == 0) begin
            if (mx + msp >= MX) begin mx = MX; mst = 1; end
            else mx = mx + msp;
        end else begin
            if (mx <= msp) begin mx = 0; mst = 2; end
            else mx = mx - msp;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; state = 2'b10; hit_right = 1'b1;
        step(); step();
        tests++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", tick); end
        tests++; if (ball_x !== 10'(OX) || ball_y !== 10'(OY)) begin
            fails++; $display("FAIL reset_pos: got (%0d,%0d) want (%0d,%0d)", ball_x, ball_y, OX, OY); end
        tests++; if (ball_status !== 2'b00) begin fails++; $display("FAIL reset_status: got %b want 00", ball_status); end
        tests++; if (speed !== 3'd1) begin fails++; $display("FAIL reset_speed: got %0d want 1", speed); end
        rst = 1'b0; state = 2'b00; hit_right = 1'b0;
        step();
    endtask

    task automatic test_serve_first_tick();
        serve_dir = 1'b0; state = 2'b01;
        step();
        tests++; if ({ball_x, ball_y, tick} !== {10'(OX), 10'(OY), 1'b0}) begin
            fails++; $display("FAIL serve_hold: got (%0d,%0d) tick %b want (%0d,%0d) tick 0", ball_x, ball_y, tick, OX, OY); end
        state = 2'b10;
        for (int c = 1; c <= 3; c++) begin
            step();
            tests++; if ({ball_x, ball_y, tick} !== {10'(OX), 10'(OY), 1'b0}) begin
                fails++; $display("FAIL first_tick_wait c%0d: got (%0d,%0d) tick %b", c, ball_x, ball_y, tick); end
        end
        step();
        tests++; if ({tick, ball_x, ball_y, speed} !== {1'b1, 10'd31, 10'd21, 3'd1}) begin
            fails++; $display("FAIL first_tick: got tick %b (%0d,%0d) spd %0d want tick 1 (31,21) spd 1", tick, ball_x, ball_y, speed); end
        step();
        tests++; if (tick !== 1'b0) begin fails++; $display("FAIL tick_pulse_width: got %b want 0", tick); end
        state = 2'b11;
        step();
        tests++; if ({ball_x, ball_y, ball_status} !== {10'(OX), 10'(OY), 2'b00}) begin
            fails++; $display("FAIL done_origin: got (%0d,%0d) st %b", ball_x, ball_y, ball_status); end
    endtask

    task automatic test_paddle_hit();
        logic [22:0] want;
        state = 2'b00; step();
        serve_dir = 1'b0; state = 2'b01; step(); step();
        state = 2'b10;
        for (int iv = 0; iv < 3; iv++) begin
            hit_left  = (iv == 0);
            hit_right = (iv != 0);
            step();
            hit_left = 1'b0; hit_right = 1'b0;
            step(); step(); step();
`ifdef BALL_SPEEDUP_EN
            case (iv)
                0: want = {10'd31, 10'd23, 3'd1};
                1: want = {10'd29, 10'd25, 3'd2};
                default: want = {10'd27, 10'd27, 3'd2};
            endcase
`else
            case (iv)
                0: want = {10'd31, 10'd23, 3'd1};
                1: want = {10'd30, 10'd24, 3'd1};
                default: want = {10'd29, 10'd25, 3'd1};
            endcase
`endif
            tests++; if ({tick, ball_x, ball_y, speed} !== {1'b1, want}) begin
                fails++; $display("FAIL paddle_hit iv%0d: got tick %b (%0d,%0d) spd %0d want (%0d,%0d) spd %0d",
                                  iv, tick, ball_x, ball_y, speed, want[22:13], want[12:3], want[2:0]); end
        end
        state = 2'b11; step();
    endtask

    task automatic test_mid_interval_change();
        state = 2'b00; step();
        serve_dir = 1'b0; state = 2'b01; step();
        state = 2'b10; step(); step();
        serve_dir = 1'b1; state = 2'b01; step();
        tests++; if ({ball_x, ball_y, tick} !== {10'(OX), 10'(OY), 1'b0}) begin
            fails++; $display("FAIL mid_change_serve: got (%0d,%0d) tick %b", ball_x, ball_y, tick); end
        state = 2'b10;
        for (int c = 1; c <= 3; c++) begin
            step();
            tests++; if (tick !== 1'b0) begin fails++; $display("FAIL mid_change_early_tick c%0d: got %b want 0", c, tick); end
        end
        step();
        tests++; if ({tick, ball_x, ball_y} !== {1'b1, 10'd29, 10'd23}) begin
            fails++; $display("FAIL mid_change_tick: got tick %b (%0d,%0d) want tick 1 (29,23)", tick, ball_x, ball_y); end
        state = 2'b11; step();
    endtask

    task automatic test_random_play();
        logic [25:0] want;
        bit lr, ll;
        int n, frozen;
        for (int g = 0; g < 8; g++) begin
            state = 2'b00; step();
            serve_dir = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 4);
            state = 2'b01;
            repeat (n) step();
            mx = OX; my = OY; mdx = int'(serve_dir); mdy = n % 2; msp = 1; mst = 0;
            state = 2'b10;
            frozen = 0;
            for (int t = 0; t < 300 && frozen < 3; t++) begin
                lr = 1'b0; ll = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    if (c < 3) begin
                        hit_right = ($urandom_range(0, 11) == 0);
                        hit_left  = ($urandom_range(0, 11) == 0);
                        lr = lr | hit_right;
                        ll = ll | hit_left;
                    end else begin
                        hit_right = 1'b0; hit_left = 1'b0;
                    end
                    step();
                    if (c == 3) model_update(lr, ll);
                    want = {(c == 3), 10'(mx), 10'(my), 2'(mst), 3'(msp)};
                    tests++;
                    if ({tick, ball_x, ball_y, ball_status, speed} !== want) begin
                        fails++;
                        $display("FAIL random_play g%0d t%0d c%0d: got tick %b (%0d,%0d) st %b spd %0d want tick %b (%0d,%0d) st %b spd %0d",
                                 g, t, c, tick, ball_x, ball_y, ball_status, speed,
                                 want[25], want[24:15], want[14:5], want[4:3], want[2:0]);
                    end
                end
                if (mst != 0) frozen++;
            end
            hit_left = 1'b0; hit_right = 1'b0;
            state = 2'b11; step();
            tests++; if ({ball_x, ball_y, ball_status, speed} !== {10'(OX), 10'(OY), 2'b00, 3'd1}) begin
                fails++; $display("FAIL random_done g%0d: got (%0d,%0d) st %b spd %0d", g, ball_x, ball_y, ball_status, speed); end
        end
    endtask

    task automatic test_reset_mid_play();
        state = 2'b00; step();
        serve_dir = 1'b0; state = 2'b01; step();
        state = 2'b10;
        hit_right = 1'b1; step();
        hit_right = 1'b0; step(); step(); step();
        step(); step();
        rst = 1'b1; step();
        tests++; if ({ball_x, ball_y, tick, speed, ball_status} !== {10'(OX), 10'(OY), 1'b0, 3'd1, 2'b00}) begin
            fails++; $display("FAIL rst_mid_play: got (%0d,%0d) tick %b spd %0d st %b", ball_x, ball_y, tick, speed, ball_status); end
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            tests++; if (tick !== 1'b0) begin fails++; $display("FAIL rst_counter c%0d: tick got %b want 0", c, tick); end
        end
        step();
        tests++; if ({tick, ball_x, ball_y, speed} !== {1'b1, 10'd31, 10'd23, 3'd1}) begin
            fails++; $display("FAIL rst_first_tick: got tick %b (%0d,%0d) spd %0d want tick 1 (31,23) spd 1", tick, ball_x, ball_y, speed); end
        state = 2'b11; step();
    endtask

    initial begin
        test_reset();
        test_serve_first_tick();
        test_paddle_hit();
        test_mid_interval_change();
        test_random_play();
        test_reset_mid_play();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
